elbeth_memory_arbiter: RTL and testbench

Shares one single-ported 16K-word (64 KiB) memory between the ELBETH instruction-fetch requester and the data-access requester. It sits between the processor-side memory bridge and the physical memory, in single-memory configurations. It grants one word transaction at a time and breaks ties by round-robin. Grant is held until the memory reports ready or error, or until an optional watchdog aborts the transaction.

---
 rtl/elbeth_memory_arbiter.sv | 158 +++++++++++++++
 tb/tb_elbeth_memory_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_memory_arbiter.sv
// Purpose: round-robin arbiter sharing one single-ported 16K-word memory between instruction fetch and data access.
// Latency: a request seen in IDLE drives mem_en on the next cycle, and ready follows mem_ready combinationally (1 cycle minimum).
// Backpressure: a requester holds en until its ready pulse, and the ungranted requester simply waits.
// Optional watchdog: define ELBETH_ARB_TIMEOUT_EN to abort busy transactions after TIMEOUT_CYCLES cycles.
module elbeth_memory_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [13:0] i_addr,
    output logic [31:0] i_in_data,
    output logic        i_ready,
    output logic        i_error,
    input  logic        d_en,
    input  logic [13:0] d_addr,
    input  logic [31:0] d_out_data,
    input  logic [3:0]  d_rw,
    output logic [31:0] d_in_data,
    output logic        d_ready,
    output logic        d_error,
    output logic        mem_en,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_out_data,
    output logic [3:0]  mem_rw,
    input  logic [31:0] mem_in_data,
    input  logic        mem_ready,
    input  logic        mem_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;      // 1: the most recent grant went to D
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  rw_q, rw_d;

    logic busy;
    logic resp;
    logic timeout;
    logic done;
    logic err;
    logic grant_i;
    logic grant_d;

    assign busy = (state_q != IDLE);
    assign resp = mem_ready | mem_error;

`ifdef ELBETH_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Busy-cycle counter: held at zero in IDLE, counts stalled busy cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = 8'd0;
        end else if (!resp) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The N-th busy cycle sees cnt_q == N-1, so the abort lands in that cycle.
    assign timeout = busy && (cnt_q == (TIMEOUT_CYCLES - 8'd1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // A real memory response beats the watchdog; only a bare timeout flags an error on its own.
    assign done = busy & (resp | timeout);
    assign err  = busy & (mem_error | (timeout & ~mem_ready));

    // On a tie the grant goes to whoever was not served last.
    assign grant_d = d_en & (~i_en | ~last_d_q);
    assign grant_i = i_en & ~grant_d;

    // Next-state, grant bookkeeping and request latching.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    addr_d   = d_addr;
                    wdata_d  = d_out_data;
                    rw_d     = d_rw;
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = 32'd0;
                    rw_d     = 4'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= 14'd0;
            wdata_q  <= 32'd0;
            rw_q     <= 4'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
        end
    end

    // Memory side is driven straight from the latched request.
    assign mem_en       = busy;
    assign mem_addr     = addr_q;
    assign mem_out_data = wdata_q;
    assign mem_rw       = rw_q;

    // Completion pulses go only to the granted side and are suppressed while reset is asserted.
    assign i_ready = rst & (state_q == BUSY_I) & done;
    assign i_error = rst & (state_q == BUSY_I) & err;
    assign d_ready = rst & (state_q == BUSY_D) & done;
    assign d_error = rst & (state_q == BUSY_D) & err;

    assign i_in_data = mem_in_data;
    assign d_in_data = mem_in_data;

endmodule

// File: tb/tb_elbeth_memory_arbiter.sv
module tb_elbeth_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [13:0] i_addr;
    logic [31:0] i_in_data;
    logic        i_ready;
    logic        i_error;
    logic        d_en;
    logic [13:0] d_addr;
    logic [31:0] d_out_data;
    logic [3:0]  d_rw;
    logic [31:0] d_in_data;
    logic        d_ready;
    logic        d_error;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_out_data;
    logic [3:0]  mem_rw;
    logic [31:0] mem_in_data;
    logic        mem_ready;
    logic        mem_error;

    int checks = 0;
    int errors = 0;

    elbeth_memory_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_addr      (i_addr),
        .i_in_data   (i_in_data),
        .i_ready     (i_ready),
        .i_error     (i_error),
        .d_en        (d_en),
        .d_addr      (d_addr),
        .d_out_data  (d_out_data),
        .d_rw        (d_rw),
        .d_in_data   (d_in_data),
        .d_ready     (d_ready),
        .d_error     (d_error),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_out_data(mem_out_data),
        .mem_rw      (mem_rw),
        .mem_in_data (mem_in_data),
        .mem_ready   (mem_ready),
        .mem_error   (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, checks follow after a further #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".i_ready"}, {31'd0, i_ready}, 32'd0);
        chk({tag, ".i_error"}, {31'd0, i_error}, 32'd0);
        chk({tag, ".d_ready"}, {31'd0, d_ready}, 32'd0);
        chk({tag, ".d_error"}, {31'd0, d_error}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; i_en = 1'b1; d_en = 1'b1;
        i_addr = 14'h0010; d_addr = 14'h0020; d_out_data = 32'hA5A5_5A5A; d_rw = 4'b1100;
        mem_in_data = 32'h0; mem_ready = 1'b0; mem_error = 1'b0;

        // Reset held for 3 cycles with both requests high.
        step(); step(); step();
        #1;
        chk("rst.mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst.mem_addr", {18'd0, mem_addr}, 32'd0);
        chk("rst.mem_rw", {28'd0, mem_rw}, 32'd0);
        chk("rst.mem_out_data", mem_out_data, 32'd0);
        chk_quiet("rst");

        // Tie and round-robin with a single-cycle memory: expect D, I, D, I.
        rst = 1'b1; mem_ready = 1'b1; mem_in_data = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk("rr.mem_en", {31'd0, mem_en}, 32'd1);
            if (k % 2 == 0) begin
                chk("rr.d_ready", {31'd0, d_ready}, 32'd1);
                chk("rr.i_ready", {31'd0, i_ready}, 32'd0);
                chk("rr.d_mem_rw", {28'd0, mem_rw}, 32'h0000_000C);
                chk("rr.d_mem_addr", {18'd0, mem_addr}, 32'h0000_0020);
                chk("rr.d_mem_out_data", mem_out_data, 32'hA5A5_5A5A);
                chk("rr.d_in_data", d_in_data, 32'h1234_5678);
            end else begin
                chk("rr.i_ready", {31'd0, i_ready}, 32'd1);
                chk("rr.d_ready", {31'd0, d_ready}, 32'd0);
                chk("rr.i_mem_rw", {28'd0, mem_rw}, 32'd0);
                chk("rr.i_mem_addr", {18'd0, mem_addr}, 32'h0000_0010);
                chk("rr.i_mem_out_data", mem_out_data, 32'd0);
            end
            chk("rr.errors", {30'd0, i_error, d_error}, 32'd0);
            // Arbiter spends one cycle in IDLE between completions.
            step(); #1;
            chk("rr.idle_mem_en", {31'd0, mem_en}, 32'd0);
            chk_quiet("rr.idle");
        end
        i_en = 1'b0; d_en = 1'b0; mem_ready = 1'b0;
        step();

        // Single read; i_en dropped after grant must not cancel the transaction.
        i_en = 1'b1; i_addr = 14'h0010; mem_in_data = 32'hDEAD_BEEF;
        step();
        i_en = 1'b0; i_addr = 14'h3FFF;
        #1;
        chk("rd.mem_en", {31'd0, mem_en}, 32'd1);
        chk("rd.mem_addr", {18'd0, mem_addr}, 32'h0000_0010);
        chk("rd.mem_rw", {28'd0, mem_rw}, 32'd0);
        chk("rd.i_ready_wait", {31'd0, i_ready}, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rd.i_ready", {31'd0, i_ready}, 32'd1);
        chk("rd.i_error", {31'd0, i_error}, 32'd0);
        chk("rd.i_in_data", i_in_data, 32'hDEAD_BEEF);
        chk("rd.d_ready", {31'd0, d_ready}, 32'd0);
        step();
        mem_ready = 1'b0;
        #1;
        chk("rd.after_mem_en", {31'd0, mem_en}, 32'd0);
        chk_quiet("rd.after");

        // Data access faulting with mem_error alone.
        d_en = 1'b1; d_addr = 14'h0030; d_rw = 4'b0000;
        step();
        d_en = 1'b0; mem_error = 1'b1;
        #1;
        chk("err.mem_addr", {18'd0, mem_addr}, 32'h0000_0030);
        chk("err.d_ready", {31'd0, d_ready}, 32'd1);
        chk("err.d_error", {31'd0, d_error}, 32'd1);
        chk("err.i_ready", {31'd0, i_ready}, 32'd0);
        chk("err.i_error", {31'd0, i_error}, 32'd0);
        step();
        mem_error = 1'b0;
        #1;
        chk("err.after_mem_en", {31'd0, mem_en}, 32'd0);
        chk_quiet("err.after");

        // mem_ready and mem_error together on an instruction fetch.
        i_en = 1'b1; i_addr = 14'h0044;
        step();
        i_en = 1'b0; mem_ready = 1'b1; mem_error = 1'b1;
        #1;
        chk("both.i_ready", {31'd0, i_ready}, 32'd1);
        chk("both.i_error", {31'd0, i_error}, 32'd1);
        chk("both.d_ready", {31'd0, d_ready}, 32'd0);
        step();
        mem_ready = 1'b0; mem_error = 1'b0;
        #1;
        chk_quiet("both.after");

        // Reset in the second busy cycle of a stalled data access.
        d_en = 1'b1; d_addr = 14'h0055; d_rw = 4'b0011;
        step();
        #1;
        chk("mrst.busy1_mem_en", {31'd0, mem_en}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("mrst.busy2_d_ready", {31'd0, d_ready}, 32'd0);
        step();
        d_en = 1'b0;
        #1;
        chk("mrst.mem_en", {31'd0, mem_en}, 32'd0);
        chk("mrst.mem_addr", {18'd0, mem_addr}, 32'd0);
        chk("mrst.mem_rw", {28'd0, mem_rw}, 32'd0);
        chk_quiet("mrst");
        rst = 1'b1;
        step();

        // Watchdog: memory never answers an instruction fetch.
        i_en = 1'b1; i_addr = 14'h0066;
        step();
        i_en = 1'b0;
`ifdef ELBETH_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("wd.mem_en", {31'd0, mem_en}, 32'd1);
            chk("wd.i_ready", {31'd0, i_ready}, (c == 4) ? 32'd1 : 32'd0);
            chk("wd.i_error", {31'd0, i_error}, (c == 4) ? 32'd1 : 32'd0);
            if (c < 4) step();
        end
        step();
        #1;
        chk("wd.after_mem_en", {31'd0, mem_en}, 32'd0);
        chk_quiet("wd.after");
`else
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 300; c++) begin
                #1;
                if (i_ready !== 1'b0 || mem_en !== 1'b1) seen++;
                step();
            end
            chk("wd.no_ready_300", seen, 32'd0);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("wd.recover_mem_en", {31'd0, mem_en}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
